// File: rtl/tier2_codestream_packer.sv
// -----------------------------------------------------------------------------
// tier2_codestream_packer
//
// Packs the byte stream of one tile codestream into OUT_BYTES-wide words,
// appends the EOC marker (0xFF 0xD9) and enforces a byte budget that always
// leaves room for that marker.  Bytes that would overrun the budget are
// dropped and flagged through 'truncated'.
//
// Ports
//   clk, rst            sole clock, synchronous active-high reset
//   start               one-cycle pulse, accepted only in IDLE
//   target_byte_number  byte budget including EOC, sampled on accepted start
//   in_valid/in_byte/in_last/in_ready  byte input handshake
//   output_to_fpga      packed word, first byte in the most-significant lane
//   output_address      byte address of output_to_fpga
//   write_en            per-lane strobe, one cycle per emitted word
//   busy, done          tile in progress / one-cycle completion pulse
//   truncated           budget was hit (valid with done, held until next start)
//   byte_count          bytes written for the tile, EOC included
// -----------------------------------------------------------------------------
module tier2_codestream_packer #(
    parameter int                    OUT_BYTES    = 4,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    BUDGET_WIDTH = 20,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BUDGET_WIDTH-1:0]   target_byte_number,
    input  logic                      in_valid,
    input  logic [7:0]                in_byte,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [8*OUT_BYTES-1:0]    output_to_fpga,
    output logic [ADDR_WIDTH-1:0]     output_address,
    output logic [OUT_BYTES-1:0]      write_en,
    output logic                      busy,
    output logic                      done,
    output logic                      truncated,
    output logic [BUDGET_WIDTH-1:0]   byte_count
);

    localparam int LANE_W = $clog2(OUT_BYTES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(OUT_BYTES - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PACK  = 3'd1;
    localparam logic [2:0] EOC1  = 3'd2;
    localparam logic [2:0] EOC2  = 3'd3;
    localparam logic [2:0] FLUSH = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    // The budget must at least hold the two EOC bytes.
    function automatic logic [BUDGET_WIDTH-1:0] sat_budget(input logic [BUDGET_WIDTH-1:0] t);
        if (t < BUDGET_WIDTH'(2)) return BUDGET_WIDTH'(2);
        return t;
    endfunction

    // Writing lane 0 starts a fresh word, so stale lanes are cleared and a
    // later partial flush carries zeros in the unused lanes.
    function automatic logic [8*OUT_BYTES-1:0] lane_insert(
        input logic [8*OUT_BYTES-1:0] cur,
        input logic [LANE_W-1:0]      lane,
        input logic [7:0]             b
    );
        logic [8*OUT_BYTES-1:0] w;
        w = (lane == '0) ? '0 : cur;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (int'(lane) == i) w[8*(OUT_BYTES-1-i) +: 8] = b;
        end
        return w;
    endfunction

    // Strobe the 'filled' most-significant lanes of a partial word.
    function automatic logic [OUT_BYTES-1:0] flush_strobe(input logic [LANE_W-1:0] filled);
        logic [OUT_BYTES-1:0] s;
        for (int i = 0; i < OUT_BYTES; i++) begin
            s[OUT_BYTES-1-i] = (i < int'(filled));
        end
        return s;
    endfunction

    logic [2:0]               state, state_nxt;
    logic [BUDGET_WIDTH-1:0]  budget_p0;
    logic [LANE_W-1:0]        lane_ptr, lane_nxt;
    logic [8*OUT_BYTES-1:0]   word_buf_p0, word_buf_nxt;
    logic [ADDR_WIDTH-1:0]    addr_p0;
    logic                     accept, keep, do_write, word_full;
    logic [7:0]               wr_byte;

    assign in_ready = (state == PACK);
    assign busy     = (state != IDLE) && (state != DONE);
    assign done     = (state == DONE);
    assign accept   = in_valid && in_ready;
    assign keep     = (byte_count < (budget_p0 - BUDGET_WIDTH'(2)));

    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        wr_byte   = 8'h00;
        case (state)
            IDLE: if (start) state_nxt = PACK;
            PACK: begin
                if (accept) begin
                    do_write = keep;
                    wr_byte  = in_byte;
                    if (in_last) state_nxt = EOC1;
                end
            end
            EOC1: begin
                do_write  = 1'b1;
                wr_byte   = 8'hFF;
                state_nxt = EOC2;
            end
            EOC2: begin
                do_write  = 1'b1;
                wr_byte   = 8'hD9;
                state_nxt = (lane_ptr == LAST_LANE) ? DONE : FLUSH;
            end
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lane_nxt     = lane_ptr;
        word_buf_nxt = word_buf_p0;
        word_full    = 1'b0;
        if (do_write) begin
            word_buf_nxt = lane_insert(word_buf_p0, lane_ptr, wr_byte);
            word_full    = (lane_ptr == LAST_LANE);
            lane_nxt     = word_full ? '0 : lane_ptr + LANE_W'(1);
        end
    end

    // ---- stage p0: lane assembly; stage p1: registered word/strobe ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            write_en       <= '0;
            output_to_fpga <= '0;
            output_address <= BASE_ADDR;
            addr_p0        <= BASE_ADDR;
            byte_count     <= '0;
            truncated      <= 1'b0;
            lane_ptr       <= '0;
        end else begin
            state    <= state_nxt;
            write_en <= '0;
            if (state == IDLE && start) begin
                lane_ptr   <= '0;
                byte_count <= '0;
                truncated  <= 1'b0;
                addr_p0    <= BASE_ADDR;
            end
            if (accept && !keep) truncated <= 1'b1;
            if (do_write) begin
                lane_ptr   <= lane_nxt;
                byte_count <= byte_count + BUDGET_WIDTH'(1);
            end
            if (word_full) begin
                output_to_fpga <= word_buf_nxt;
                write_en       <= '1;
                output_address <= addr_p0;
                addr_p0        <= addr_p0 + ADDR_WIDTH'(OUT_BYTES);
            end
            if (state == FLUSH) begin
                output_to_fpga <= word_buf_p0;
                write_en       <= flush_strobe(lane_ptr);
                output_address <= addr_p0;
                addr_p0        <= addr_p0 + ADDR_WIDTH'(OUT_BYTES);
                lane_ptr       <= '0;
            end
        end
    end

    // Data path registers carry no reset; lane 0 writes re-initialise them.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) budget_p0 <= sat_budget(target_byte_number);
        if (do_write) word_buf_p0 <= word_buf_nxt;
    end

endmodule

// File: doc/tier2_codestream_packer.md
TIER2_CODESTREAM_PACKER -- requirements
Module: tier2_codestream_packer

Interface
REQ-001 SHALL have parameter OUT_BYTES, default 4, output word width in bytes (legal 2, 4, 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter BUDGET_WIDTH, default 20, width of the byte budget and byte counter.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of the first output word.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  one-cycle pulse that begins one tile codestream.
REQ-009 target_byte_number  in  BUDGET_WIDTH  total byte budget including the EOC marker; sampled on an accepted start.
REQ-010 in_valid  in  1  in_byte is valid.
REQ-011 in_byte  in  8  codestream byte.
REQ-012 in_last  in  1  marks the final input byte of the tile.
REQ-013 in_ready  out  1  byte accepted when in_valid & in_ready.
REQ-014 output_to_fpga  out  8*OUT_BYTES  packed word, first byte in the most-significant lane.
REQ-015 output_address  out  ADDR_WIDTH  byte address of output_to_fpga.
REQ-016 write_en  out  OUT_BYTES  per-lane byte strobe; MSB corresponds to the MS lane.
REQ-017 busy  out  1  high from accepted start until done.
REQ-018 done  out  1  one-cycle pulse when the tile is complete.
REQ-019 truncated  out  1  budget was hit; valid with done, held until next start.
REQ-020 byte_count  out  BUDGET_WIDTH  bytes written for the tile, EOC included.

Function
REQ-021 SHALL implement states IDLE, PACK, EOC1, EOC2, FLUSH, DONE.
REQ-022 IDLE: in_ready=0; start -> PACK; latch budget = max(target_byte_number, 2); clear lane pointer, byte_count, truncated; address <= BASE_ADDR.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 PACK: in_ready=1; each accepted byte with byte_count < budget-2 is written into the current lane and increments byte_count.
REQ-025 PACK: an accepted byte with byte_count >= budget-2 is discarded and sets truncated=1.
REQ-026 When a byte fills the last lane, the next cycle SHALL present the word with write_en all ones at the current address; the address then advances by OUT_BYTES.
REQ-027 write_en SHALL be high for exactly one cycle per word; it is zero otherwise.
REQ-028 An accepted byte with in_last=1 (kept or discarded) SHALL move PACK -> EOC1.
REQ-029 EOC1 inserts 0xFF and EOC2 inserts 0xD9, using the same lane and word rules; in_ready=0.
REQ-030 EOC2 -> FLUSH if the lane pointer is nonzero, otherwise -> DONE.
REQ-031 FLUSH SHALL emit the partial word: unused lanes are 0x00 and only the filled lanes are strobed.
REQ-032 DONE: done=1 for one cycle, busy=0, then IDLE.
REQ-033 byte_count SHALL never exceed budget; lane pointer wraps modulo OUT_BYTES.
REQ-034 In-flight words SHALL be committed in order with no gaps; output_address is monotonically increasing within a tile.
REQ-035 Cycles with in_valid=0 in PACK SHALL hold all state.

Reset
REQ-036 rst SHALL force IDLE; all outputs to 0, output_address to BASE_ADDR; byte_count, truncated and the lane pointer to 0.
REQ-037 rst mid-tile SHALL abandon the partial word without any write_en.

Verification (OUT_BYTES=4, BASE_ADDR=0)
REQ-038 Budget 100, bytes 01..06 last -> 0x01020304 we=1111 @0; 0x0506FFD9 we=1111 @4; done, byte_count=8, truncated=0.
REQ-039 Budget 6, bytes 01..0A last -> 0x01020304 @0; 0xFFD90000 we=1100 @4; truncated=1, byte_count=6.
REQ-040 Budget 100, bytes AA BB CC last -> 0xAABBCCFF we=1111 @0; 0xD9000000 we=1000 @4; byte_count=5.
REQ-041 Budget 0, single byte 55 last -> 0xFFD90000 we=1100 @0; truncated=1, byte_count=2.
REQ-042 rst after 5 bytes accepted -> next cycle busy=0, write_en=0; a new start writes from @0 again.
REQ-043 Random in_valid gaps plus start pulses while busy -> output identical to the gap-free run; extra starts have no effect.
